// File: rtl/usb_jtag_fifo_pkg.sv
// usb_jtag_fifo_pkg: shared defaults for the USB-Blaster JTAG bridge
package usb_jtag_fifo_pkg;
    localparam int   DEF_DATA_W   = 8;
    localparam int   DEF_RX_DEPTH = 16;
    localparam int   DEF_TX_DEPTH = 16;
    localparam logic TDO_IDLE     = 1'b0;
endpackage

// File: rtl/jtag_sync_fifo.sv
// jtag_sync_fifo: single-clock show-ahead FIFO with level and simultaneous push/pop
module jtag_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     iCLK,
    input  logic                     iRST_n,
    input  logic [DATA_W-1:0]        iData,
    input  logic                     iPush,
    input  logic                     iPop,
    output logic [DATA_W-1:0]        oData,
    output logic                     oFull,
    output logic                     oEmpty,
    output logic [$clog2(DEPTH):0]   oLevel
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wrPtr, rdPtr;
    logic              wrEn, rdEn;

    assign oFull  = oLevel == (AW+1)'(DEPTH);
    assign oEmpty = oLevel == '0;
    assign rdEn   = iPop & ~oEmpty;
    // a pop frees the slot this cycle, so a full FIFO still takes the push
    assign wrEn   = iPush & (~oFull | rdEn);
    assign oData  = oEmpty ? '0 : mem[rdPtr];

    always_ff @(posedge iCLK)
        if (wrEn) mem[wrPtr] <= iData;

    always_ff @(posedge iCLK) begin
        if (iRST_n) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            oLevel <= '0;
        end else begin
            if (wrEn) wrPtr <= wrPtr + AW'(1);
            if (rdEn) rdPtr <= rdPtr + AW'(1);
            oLevel <= oLevel + (AW+1)'(wrEn) - (AW+1)'(rdEn);
        end
    end
endmodule

// File: rtl/usb_jtag_fifo.sv
// usb_jtag_fifo: oversampling JTAG bridge that deserialises TDI into an RX FIFO
// and serialises a TX FIFO onto TDO, with valid/ready host streams.
module usb_jtag_fifo
    import usb_jtag_fifo_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int RX_DEPTH    = DEF_RX_DEPTH,
    parameter int TX_DEPTH    = DEF_TX_DEPTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        iCLK,
    input  logic                        iRST_n,
    input  logic [DATA_W-1:0]           iTxD_DATA,
    input  logic                        iTxD_Valid,
    output logic                        oTxD_Ready,
    output logic [DATA_W-1:0]           oRxD_DATA,
    output logic                        oRxD_Valid,
    input  logic                        iRxD_Ready,
    output logic [$clog2(RX_DEPTH):0]   oRx_Level,
    output logic [$clog2(TX_DEPTH):0]   oTx_Level,
    output logic                        oRx_Overrun,
    output logic                        oTx_Underrun,
    input  logic                        iClr_Err,
    input  logic                        TCK,
    input  logic                        TCS,
    input  logic                        TDI,
    output logic                        TDO
);
    localparam int CW = $clog2(DATA_W);

    logic [SYNC_STAGES-1:0] tckSh, tcsSh, tdiSh;
    logic                   tckD, tckSync, tcsSync, tdiSync, tckRise;
    logic [CW-1:0]          bitCnt;
    logic                   lastBit, slotStart, rxPushPend;
    logic [DATA_W-1:0]      rxSr, txSr, txHead;
    logic                   rxFull, rxEmpty, txFull, txEmpty, txPop;

    assign tckSync   = tckSh[SYNC_STAGES-1];
    assign tcsSync   = tcsSh[SYNC_STAGES-1];
    assign tdiSync   = tdiSh[SYNC_STAGES-1];
    assign tckRise   = tckSync & ~tckD & ~tcsSync;
    assign lastBit   = bitCnt == CW'(DATA_W-1);
    assign slotStart = bitCnt == '0;
    assign txPop     = tckRise & slotStart;

    // TCS chain resets to the inactive level so no frame is seen until the pin is sampled
    always_ff @(posedge iCLK) begin
        if (iRST_n) begin
            tckSh <= '0;
            tcsSh <= '1;
            tdiSh <= '0;
            tckD  <= 1'b0;
        end else begin
            tckSh <= {tckSh[SYNC_STAGES-2:0], TCK};
            tcsSh <= {tcsSh[SYNC_STAGES-2:0], TCS};
            tdiSh <= {tdiSh[SYNC_STAGES-2:0], TDI};
            tckD  <= tckSync;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST_n || tcsSync) begin
            bitCnt <= '0;
            rxSr   <= '0;
            txSr   <= '0;
            TDO    <= TDO_IDLE;
        end else if (tckRise) begin
            bitCnt <= lastBit ? '0 : bitCnt + CW'(1);
            rxSr   <= {tdiSync, rxSr[DATA_W-1:1]};
            TDO    <= slotStart ? (txEmpty ? TDO_IDLE : txHead[0]) : txSr[0];
            txSr   <= slotStart ? (txEmpty ? '0 : txHead >> 1) : txSr >> 1;
        end
    end

    // completed word sits in rxSr for the cycle after its last rise
    always_ff @(posedge iCLK) begin
        if (iRST_n) rxPushPend <= 1'b0;
        else        rxPushPend <= tckRise & lastBit;
    end

    always_ff @(posedge iCLK) begin
        if (iRST_n || iClr_Err) begin
            oRx_Overrun  <= 1'b0;
            oTx_Underrun <= 1'b0;
        end else begin
            if (rxPushPend & rxFull & ~iRxD_Ready) oRx_Overrun <= 1'b1;
            if (txPop & txEmpty) oTx_Underrun <= 1'b1;
        end
    end

    assign oTxD_Ready = ~txFull;
    assign oRxD_Valid = ~rxEmpty;

    jtag_sync_fifo #(.DATA_W(DATA_W), .DEPTH(RX_DEPTH)) uRxFifo (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .iData  (rxSr),
        .iPush  (rxPushPend),
        .iPop   (iRxD_Ready),
        .oData  (oRxD_DATA),
        .oFull  (rxFull),
        .oEmpty (rxEmpty),
        .oLevel (oRx_Level)
    );

    jtag_sync_fifo #(.DATA_W(DATA_W), .DEPTH(TX_DEPTH)) uTxFifo (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .iData  (iTxD_DATA),
        .iPush  (iTxD_Valid),
        .iPop   (txPop),
        .oData  (txHead),
        .oFull  (txFull),
        .oEmpty (txEmpty),
        .oLevel (oTx_Level)
    );
endmodule

// File: tb/tb_usb_jtag_fifo.sv
// tb_usb_jtag_fifo: randomized JTAG/host traffic checked against a queue-based
// word-level model of the bridge.
module tb_usb_jtag_fifo;
    localparam int W = 8;
    localparam int D = 16;

    logic         iCLK = 1'b0;
    logic         iRST_n = 1'b1;
    logic [W-1:0] iTxD_DATA = '0;
    logic         iTxD_Valid = 1'b0;
    logic         oTxD_Ready;
    logic [W-1:0] oRxD_DATA;
    logic         oRxD_Valid;
    logic         iRxD_Ready = 1'b0;
    logic [4:0]   oRx_Level, oTx_Level;
    logic         oRx_Overrun, oTx_Underrun;
    logic         iClr_Err = 1'b0;
    logic         TCK = 1'b0, TCS = 1'b1, TDI = 1'b0;
    logic         TDO;

    usb_jtag_fifo #(.DATA_W(W), .RX_DEPTH(D), .TX_DEPTH(D), .SYNC_STAGES(2)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n),
        .iTxD_DATA(iTxD_DATA), .iTxD_Valid(iTxD_Valid), .oTxD_Ready(oTxD_Ready),
        .oRxD_DATA(oRxD_DATA), .oRxD_Valid(oRxD_Valid), .iRxD_Ready(iRxD_Ready),
        .oRx_Level(oRx_Level), .oTx_Level(oTx_Level),
        .oRx_Overrun(oRx_Overrun), .oTx_Underrun(oTx_Underrun), .iClr_Err(iClr_Err),
        .TCK(TCK), .TCS(TCS), .TDI(TDI), .TDO(TDO)
    );

    always #5 iCLK = ~iCLK;

    int           checks = 0, errors = 0;
    logic [W-1:0] rxQ[$], txQ[$];
    int           mCnt = 0;
    logic [W-1:0] mRx = '0, mTx = '0;
    logic         mOv = 1'b0, mUn = 1'b0;
    logic [W-1:0] head;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic chkState(input string tag);
        check({tag, ".rxlvl"}, 32'(oRx_Level), rxQ.size());
        check({tag, ".txlvl"}, 32'(oTx_Level), txQ.size());
        check({tag, ".rxvld"}, 32'(oRxD_Valid), 32'(rxQ.size() != 0));
        check({tag, ".rxdat"}, 32'(oRxD_DATA), rxQ.size() != 0 ? 32'(rxQ[0]) : 32'd0);
        check({tag, ".txrdy"}, 32'(oTxD_Ready), 32'(txQ.size() < D));
        check({tag, ".ovr"}, 32'(oRx_Overrun), 32'(mOv));
        check({tag, ".udr"}, 32'(oTx_Underrun), 32'(mUn));
    endtask

    // mode 0: plain bit; 1: check RX valid latency; 2: pulse iRxD_Ready in the push cycle
    task automatic jtagBit(input logic tdi, input int mode);
        logic expTdo;
        TDI = tdi;
        TCK = 1'b1;
        mRx[mCnt] = tdi;
        if (mCnt == 0) begin
            if (txQ.size() != 0) mTx = txQ.pop_front();
            else begin
                mTx = '0;
                mUn = 1'b1;
            end
        end
        expTdo = mTx[mCnt];
        if (mCnt == W-1) begin
            if (mode == 2 && rxQ.size() != 0) void'(rxQ.pop_front());
            if (rxQ.size() < D) rxQ.push_back(mRx);
            else mOv = 1'b1;
        end
        mCnt = (mCnt + 1) % W;
        if (mode == 1) begin
            cyc(3);
            check("lat.pre", 32'(oRxD_Valid), 32'd0);
            cyc(1);
            check("lat.post", 32'(oRxD_Valid), 32'd1);
        end else if (mode == 2) begin
            cyc(3);
            iRxD_Ready = 1'b1;
            cyc(1);
            iRxD_Ready = 1'b0;
        end else cyc(4);
        TCK = 1'b0;
        cyc(4);
        check("tdo", 32'(TDO), 32'(expTdo));
    endtask

    task automatic sendWord(input logic [W-1:0] d, input int mode);
        for (int i = 0; i < W; i++) jtagBit(d[i], i == W-1 ? mode : 0);
    endtask

    task automatic txWrite(input logic [W-1:0] d);
        check("txw.rdy", 32'(oTxD_Ready), 32'(txQ.size() < D));
        iTxD_DATA = d;
        iTxD_Valid = 1'b1;
        cyc(1);
        iTxD_Valid = 1'b0;
        if (txQ.size() < D) txQ.push_back(d);
    endtask

    task automatic rxRead();
        check("rxr.vld", 32'(oRxD_Valid), 32'(rxQ.size() != 0));
        if (rxQ.size() != 0) check("rxr.dat", 32'(oRxD_DATA), 32'(rxQ[0]));
        iRxD_Ready = 1'b1;
        cyc(1);
        iRxD_Ready = 1'b0;
        if (rxQ.size() != 0) void'(rxQ.pop_front());
    endtask

    task automatic clrErr();
        iClr_Err = 1'b1;
        cyc(1);
        iClr_Err = 1'b0;
        mOv = 1'b0;
        mUn = 1'b0;
    endtask

    task automatic tcsPulse();
        TCS = 1'b1;
        cyc(4);
        check("tcs.tdo", 32'(TDO), 32'd0);
        TCS = 1'b0;
        cyc(4);
        mCnt = 0;
    endtask

    task automatic doReset();
        iRST_n = 1'b1;
        cyc(1);
        iRST_n = 1'b0;
        rxQ.delete();
        txQ.delete();
        mCnt = 0;
        mTx = '0;
        mOv = 1'b0;
        mUn = 1'b0;
    endtask

    initial begin
        cyc(2);
        doReset();
        chkState("rst");
        check("rst.tdo", 32'(TDO), 32'd0);
        TCS = 1'b0;
        cyc(4);

        sendWord(8'hA5, 1);
        chkState("a5");
        rxRead();

        txWrite(8'h3C);
        txWrite(8'hF0);
        chkState("txload");
        sendWord(W'($urandom), 0);
        sendWord(W'($urandom), 0);
        chkState("txdone");
        while (rxQ.size() != 0) rxRead();

        for (int i = 0; i < D; i++) sendWord(W'($urandom), 0);
        chkState("fill");
        head = rxQ[0];
        sendWord(W'($urandom), 0);
        chkState("ovr");
        check("ovr.head", 32'(oRxD_DATA), 32'(head));
        clrErr();
        sendWord(W'($urandom), 2);
        chkState("pushpop");
        while (rxQ.size() != 0) rxRead();

        clrErr();
        sendWord(W'($urandom), 0);
        chkState("udr");
        clrErr();
        chkState("clr");
        rxRead();

        for (int i = 0; i < 5; i++) jtagBit(1'($urandom), 0);
        tcsPulse();
        sendWord(8'h81, 0);
        chkState("abort");
        rxRead();

        for (int it = 0; it < 24; it++) begin
            int n;
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) txWrite(W'($urandom));
            if ($urandom_range(0, 5) == 0) begin
                n = $urandom_range(1, W-1);
                for (int k = 0; k < n; k++) jtagBit(1'($urandom), 0);
                tcsPulse();
            end
            sendWord(W'($urandom), 0);
            if ($urandom_range(0, 1) == 1) rxRead();
            if ($urandom_range(0, 3) == 0) clrErr();
            chkState("rand");
        end

        while (rxQ.size() != 0) rxRead();
        while (txQ.size() != 0) sendWord(W'($urandom), 0);
        for (int i = 0; i < 3; i++) sendWord(W'($urandom), 0);
        for (int i = 0; i < 3; i++) txWrite(8'hFF);
        for (int i = 0; i < 3; i++) jtagBit(1'($urandom), 0);
        check("pre.tdo", 32'(TDO), 32'd1);
        doReset();
        chkState("midrst");
        check("midrst.tdo", 32'(TDO), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
